aligned_ram_ctrl: RTL and testbench

//  Parametrised single-port byte-addressed RAM with a size-aware alignment checker.

---
 rtl/aligned_ram_pkg.sv | 31 +++
 rtl/aligned_ram_bemask.sv | 40 ++++
 rtl/aligned_ram_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_aligned_ram_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aligned_ram_pkg.sv
//------------------------------------------------------------------------------
// Module : aligned_ram_pkg
// Brief  : Shared types and the size/offset alignment helper for aligned_ram_ctrl.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package aligned_ram_pkg;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD} size_e;
    typedef enum logic {ST_IDLE, ST_RESP} state_e;

    // Widest supported word is 64 bits, so a byte offset never exceeds 3 bits.
    localparam int MAX_OFF_W = 3;

    function automatic logic align_ok(
        input logic [MAX_OFF_W-1:0] addr_off,
        input logic [1:0]           size,
        input int                   off_w
    );
        logic [MAX_OFF_W-1:0] mask;
        if (int'(size) > off_w) begin
            return 1'b0;
        end
        mask = MAX_OFF_W'((1 << size) - 1);
        return (addr_off & mask) == '0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aligned_ram_bemask.sv
//------------------------------------------------------------------------------
// Module : aligned_ram_bemask
// Brief  : Byte-enable and right-aligned read mask for a sized sub-word access.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module aligned_ram_bemask
    import aligned_ram_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int BYTES  = DATA_W / 8,
    localparam int OFF_W  = $clog2(BYTES)
) (
    input  logic [OFF_W-1:0]  offset_i,
    input  size_e             size_i,
    output logic [BYTES-1:0]  byte_en_o,
    output logic [DATA_W-1:0] rd_mask_o
);

    logic [3:0] w_nbytes;

    assign w_nbytes = 4'd1 << size_i;

    always_comb begin
        byte_en_o = '0;
        rd_mask_o = '0;
        for (int i = 0; i < BYTES; i++) begin
            if ((i >= int'(offset_i)) && (i < int'(offset_i) + int'(w_nbytes))) begin
                byte_en_o[i] = 1'b1;
            end
            if (i < int'(w_nbytes)) begin
                rd_mask_o[i*8 +: 8] = 8'hFF;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/aligned_ram_ctrl.sv
//------------------------------------------------------------------------------
// Module : aligned_ram_ctrl
// Brief  : Single-port byte-addressed RAM with size-aware alignment checking,
//          error counting and optional first-fault capture
//          (ALIGNED_RAM_ERR_CAPTURE_EN).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module aligned_ram_ctrl
    import aligned_ram_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = 32,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                err_flag,
    input  logic                err_clr,
    output logic [ERRCNT_W-1:0] err_cnt
`ifdef ALIGNED_RAM_ERR_CAPTURE_EN
    ,
    output logic [ADDR_W-1:0]   err_addr,
    output logic                err_we
`endif
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HI_W  = ADDR_W - OFF_W;

    state_e                state_q;
    state_e                state_d;
    logic [DATA_W-1:0]     rsp_rdata_q;
    logic                  rsp_err_q;
    logic                  err_flag_q;
    logic [ERRCNT_W-1:0]   err_cnt_q;

    logic [DATA_W-1:0]     mem [DEPTH];

    logic [OFF_W-1:0]      offset;
    logic [HI_W-1:0]       word_idx;
    logic [IDX_W-1:0]      mem_idx;
    logic                  range_err;
    logic                  align_err;
    logic                  req_err;
    logic                  acc;
    logic                  acc_err;
    logic [BYTES-1:0]      byte_en;
    logic [DATA_W-1:0]     rd_mask;
    logic [DATA_W-1:0]     rd_word;
    logic [DATA_W-1:0]     rd_aligned;
    logic [DATA_W-1:0]     wdata_sh;

    assign offset    = req_addr[OFF_W-1:0];
    assign word_idx  = req_addr[ADDR_W-1:OFF_W];
    assign mem_idx   = word_idx[IDX_W-1:0];
    assign range_err = ADDR_W'(word_idx) >= ADDR_W'(DEPTH);
    assign align_err = !align_ok(MAX_OFF_W'(offset), req_size, OFF_W);
    assign req_err   = range_err || align_err;

    assign acc       = req_valid && req_ready;
    assign acc_err   = acc && req_err;

    aligned_ram_bemask #(
        .DATA_W    (DATA_W)
    ) u_bemask (
        .offset_i  (offset),
        .size_i    (size_e'(req_size)),
        .byte_en_o (byte_en),
        .rd_mask_o (rd_mask)
    );

    assign rd_word    = mem[mem_idx];
    assign rd_aligned = (rd_word >> {offset, 3'b000}) & rd_mask;
    assign wdata_sh   = req_wdata << {offset, 3'b000};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Response is captured at the accept edge and held until the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (acc) begin
            rsp_err_q   <= req_err;
            rsp_rdata_q <= (req_err || req_we) ? '0 : rd_aligned;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (acc && req_we && !req_err && !rst) begin
            for (int b = 0; b < BYTES; b++) begin
                if (byte_en[b]) begin
                    mem[mem_idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
                end
            end
        end
    end

    // A clear in the same cycle as an error leaves the new error counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
        end else if (err_clr) begin
            err_cnt_q  <= acc_err ? ERRCNT_W'(1) : '0;
            err_flag_q <= acc_err;
        end else if (acc_err) begin
            err_flag_q <= 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

`ifdef ALIGNED_RAM_ERR_CAPTURE_EN
    logic [ADDR_W-1:0] err_addr_q;
    logic              err_we_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_addr_q <= '0;
            err_we_q   <= 1'b0;
        end else if (err_clr) begin
            err_addr_q <= acc_err ? req_addr : '0;
            err_we_q   <= acc_err && req_we;
        end else if (acc_err && !err_flag_q) begin
            err_addr_q <= req_addr;
            err_we_q   <= req_we;
        end
    end

    assign err_addr = err_addr_q;
    assign err_we   = err_we_q;
`endif

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign err_flag  = err_flag_q;
    assign err_cnt   = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_aligned_ram_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_aligned_ram_ctrl
// Brief  : Scoreboard bench for aligned_ram_ctrl against a byte-array model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_aligned_ram_ctrl;

    localparam int DATA_W   = 32;
    localparam int DEPTH    = 256;
    localparam int ADDR_W   = 32;
    localparam int ERRCNT_W = 8;

    logic                clk;
    logic                rst;
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [1:0]          req_size;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;
    logic                err_flag;
    logic                err_clr;
    logic [ERRCNT_W-1:0] err_cnt;
`ifdef ALIGNED_RAM_ERR_CAPTURE_EN
    logic [ADDR_W-1:0]   err_addr;
    logic                err_we;
`endif

    aligned_ram_ctrl #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ERRCNT_W (ERRCNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .err_flag  (err_flag),
        .err_clr   (err_clr),
        .err_cnt   (err_cnt)
`ifdef ALIGNED_RAM_ERR_CAPTURE_EN
        ,
        .err_addr  (err_addr),
        .err_we    (err_we)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic [7:0]  mmem [DEPTH*4];
    rsp_t        exp_q [$];
    int          m_cnt;
    logic        m_flag;
    logic [31:0] m_cap_addr;
    logic        m_cap_we;
    bit          lat_pend;
    int          n_checks;
    int          n_fail;
    int          rdy_mode;
    logic [31:0] last_rdata;
    logic        last_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: observes accepts (inputs are stable from negedge to the next posedge).
    always @(negedge clk) begin : p_model
        bit          e;
        int          nb;
        logic [31:0] rd;
        rsp_t        r;
        e = 1'b0;
        if (rst) begin
            exp_q.delete();
            m_cnt      = 0;
            m_flag     = 1'b0;
            m_cap_addr = '0;
            m_cap_we   = 1'b0;
            lat_pend   = 1'b0;
        end else begin
            if (lat_pend) begin
                check("latency_rsp_valid", rsp_valid, 1);
                lat_pend = 1'b0;
            end
            if (req_valid && req_ready) begin
                nb = 1 << req_size;
                e  = (req_size > 2) || ((req_addr % nb) != 0) || (req_addr >= DEPTH*4);
                rd = '0;
                if (!e) begin
                    for (int k = 0; k < nb; k++) begin
                        if (req_we) mmem[int'(req_addr) + k] = req_wdata[8*k +: 8];
                        else        rd[8*k +: 8] = mmem[int'(req_addr) + k];
                    end
                end
                r.rdata = rd;
                r.err   = e;
                exp_q.push_back(r);
                lat_pend = 1'b1;
            end
            if (err_clr) begin
                m_cnt      = e ? 1 : 0;
                m_flag     = e;
                m_cap_addr = e ? req_addr : '0;
                m_cap_we   = e && req_we;
            end else if (e) begin
                if (!m_flag) begin
                    m_cap_addr = req_addr;
                    m_cap_we   = req_we;
                end
                m_flag = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
        end
    end

    // Monitor: compares every presented response at its handshake.
    always @(negedge clk) begin : p_monitor
        rsp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rdata 0x%0h with no expected entry", rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", rsp_err, e.err);
                last_rdata = rsp_rdata;
                last_err   = rsp_err;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = ($urandom_range(0, 3) != 0);
            default: rsp_ready = 1'b0;
        endcase
    end

    task automatic do_req(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd, input logic clr);
        int t;
        t = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_size  = sz;
        req_addr  = addr;
        req_wdata = wd;
        err_clr   = clr;
        @(negedge clk);
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout: req_ready stuck at 0 for addr 0x%0h", addr);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || rsp_valid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0 || rsp_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held;
        logic [1:0]  sz;
        logic [31:0] addr;
        n_checks  = 0;
        n_fail    = 0;
        rdy_mode  = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = '0;
        req_addr  = '0;
        req_wdata = '0;
        err_clr   = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_req_ready", req_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        check("reset_err_flag", err_flag, 0);
        check("reset_err_cnt", err_cnt, 0);

        for (int w = 0; w < DEPTH; w++) do_req(1'b1, 2'd2, w*4, $urandom, 1'b0);
        drain();

        // Full-word write and read back
        do_req(1'b1, 2'd2, 32'h4, 32'hDEADBEEF, 1'b0);
        do_req(1'b0, 2'd2, 32'h4, 32'h0, 1'b0);
        drain();
        check("t1_rdata", last_rdata, 32'hDEADBEEF);
        check("t1_err", last_err, 0);

        // Sub-word merge
        do_req(1'b1, 2'd0, 32'h5, 32'h12, 1'b0);
        do_req(1'b1, 2'd1, 32'h6, 32'hA55A, 1'b0);
        do_req(1'b0, 2'd2, 32'h4, 32'h0, 1'b0);
        drain();
        check("t2_word", last_rdata, 32'hA55A12EF);
        do_req(1'b0, 2'd1, 32'h6, 32'h0, 1'b0);
        drain();
        check("t2_half", last_rdata, 32'h0000A55A);

        // Misaligned, out-of-range and oversize accesses
        do_req(1'b1, 2'd2, 32'h5, 32'h11111111, 1'b0);
        do_req(1'b1, 2'd1, 32'h3, 32'h00002222, 1'b0);
        do_req(1'b1, 2'd2, 32'h400, 32'h33333333, 1'b0);
        do_req(1'b1, 2'd3, 32'h8, 32'h44444444, 1'b0);
        drain();
        check("t3_err_cnt", err_cnt, 4);
        check("t3_err_flag", err_flag, 1);
        check("t3_last_err", last_err, 1);
        do_req(1'b0, 2'd2, 32'h4, 32'h0, 1'b0);
        drain();
        check("t3_mem_unchanged", last_rdata, 32'hA55A12EF);

        // Back-pressure: response held, new request stalled
        rdy_mode = 2;
        do_req(1'b0, 2'd2, 32'h4, 32'h0, 1'b0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd2;
        req_addr  = 32'h10;
        req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        held = rsp_rdata;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t4_req_ready_low", req_ready, 0);
            check("t4_rsp_valid_held", rsp_valid, 1);
            check("t4_rsp_rdata_stable", rsp_rdata, held);
            check("t4_rsp_rdata", rsp_rdata, 32'hA55A12EF);
        end
        rdy_mode = 0;
        do_req(1'b1, 2'd2, 32'h10, 32'hCAFEF00D, 1'b0);
        do_req(1'b0, 2'd2, 32'h10, 32'h0, 1'b0);
        drain();
        check("t4_write_after_stall", last_rdata, 32'hCAFEF00D);

        // Clear racing an error, then saturation
        do_req(1'b0, 2'd2, 32'h2, 32'h0, 1'b1);
        drain();
        check("t5_clr_err_cnt", err_cnt, 1);
        check("t5_clr_err_flag", err_flag, 1);
        for (int i = 0; i < 300; i++) begin
            do_req(1'($urandom_range(0, 1)), 2'd2, (i*4) | 1, $urandom, 1'b0);
        end
        drain();
        check("t5_sat_err_cnt", err_cnt, 255);
        check("t5_sat_err_flag", err_flag, 1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("t5_cleared_cnt", err_cnt, 0);
        check("t5_cleared_flag", err_flag, 0);

`ifdef ALIGNED_RAM_ERR_CAPTURE_EN
        do_req(1'b1, 2'd2, 32'h5, 32'h0, 1'b0);
        do_req(1'b0, 2'd2, 32'h7, 32'h0, 1'b0);
        drain();
        check("t6_err_addr", err_addr, 32'h5);
        check("t6_err_we", err_we, 1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("t6_clr_addr", err_addr, 0);
        check("t6_clr_we", err_we, 0);
        do_req(1'b0, 2'd1, 32'h7, 32'h0, 1'b0);
        drain();
        check("t6_recap_addr", err_addr, 32'h7);
        check("t6_recap_we", err_we, 0);
`endif

        // Reset while a write response is pending
        rdy_mode = 2;
        do_req(1'b1, 2'd2, 32'h20, 32'h5EC0DE00, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_mode = 0;
        check("rst_mid_rsp_valid", rsp_valid, 0);
        check("rst_mid_err_cnt", err_cnt, 0);
        do_req(1'b0, 2'd2, 32'h20, 32'h0, 1'b0);
        drain();
        check("rst_write_kept", last_rdata, 32'h5EC0DE00);

        // Randomized traffic with random back-pressure and occasional clears
        rdy_mode = 1;
        for (int i = 0; i < 400; i++) begin
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) addr = $urandom_range(1024, 1200);
            else                           addr = $urandom_range(0, 1023);
            if ($urandom_range(0, 1) == 1 && sz != 2'd3) addr = addr & ~((32'd1 << sz) - 1);
            do_req(1'($urandom_range(0, 1)), sz, addr, $urandom, 1'($urandom_range(0, 19) == 0));
        end
        drain();
        rdy_mode = 0;
        check("rand_err_cnt", err_cnt, m_cnt);
        check("rand_err_flag", err_flag, m_flag);
`ifdef ALIGNED_RAM_ERR_CAPTURE_EN
        check("rand_err_addr", err_addr, m_cap_addr);
        check("rand_err_we", err_we, m_cap_we);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
